// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - wait-state memory responder for the CPU memory bus
//
// Purpose: word-addressed RAM that serves one read or write at a time after a
// fixed LATENCY and flags completion with a one-cycle inputReady pulse.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - synchronous active-low reset (RAM contents preserved)
//   readM      - read request, sampled only in IDLE
//   writeM     - write request, sampled only in IDLE
//   address    - word address; bits above ADDR_BITS-1 are ignored
//   data       - bidirectional bus; driven here only in the response cycle of a read
//   inputReady - one-cycle completion pulse
//   busy       - request in flight (WAIT or RESP)
//   proto_err  - sticky: readM and writeM seen together in IDLE
//   acc_count  - completed accesses, wraps
module mem_bus_responder #(
    parameter int    WORD_SIZE = 16,
    parameter int    ADDR_BITS = 8,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    output logic                 busy,
    output logic                 proto_err,
    output logic [WORD_SIZE-1:0] acc_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   is_rd_q, is_rd_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic                   perr_q, perr_d;
    logic [WORD_SIZE-1:0]   acc_q, acc_d;
    logic [WORD_SIZE-1:0]   rdata_q;
    logic                   enter_resp;

    logic [WORD_SIZE-1:0]   mem_q [2**ADDR_BITS];

    logic                   unused_addr_hi;
    assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];

    // The accept edge counts as the first of the LATENCY edges: with
    // LATENCY=1 the accept edge itself enters RESP, otherwise the counter
    // holds the remaining edges and RESP is entered from WAIT when it reads 1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_rd_d    = is_rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        perr_d     = perr_q;
        acc_d      = acc_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (readM && writeM) begin
                    perr_d = 1'b1;
                end else if (readM || writeM) begin
                    is_rd_d = readM;
                    addr_d  = address[ADDR_BITS-1:0];
                    wdata_d = data;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            acc_d = acc_q + WORD_SIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            is_rd_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            perr_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_rd_q <= is_rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            perr_q  <= perr_d;
            acc_q   <= acc_d;
        end
    end

    // The commit uses the _d copies so the LATENCY=1 case, which latches and
    // commits on the same edge, sees the freshly accepted request. Reset
    // suppresses the commit, so an aborted write never reaches the RAM.
    always_ff @(posedge clk) begin
        if (reset_n && enter_resp) begin
            if (is_rd_d) begin
                rdata_q <= mem_q[addr_d];
            end else begin
                mem_q[addr_d] <= wdata_d;
            end
        end
    end

    assign data       = (state_q == ST_RESP && is_rd_q) ? rdata_q : {WORD_SIZE{1'bz}};
    assign inputReady = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign proto_err  = perr_q;
    assign acc_count  = acc_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - self-checking bench for mem_bus_responder
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        reset_n, readM, writeM;
    logic [15:0] address, cpu_val;
    logic        cpu_en [2];
    wire  [15:0] data2, data1;
    logic        ready2, busy2, perr2, ready1, busy1, perr1;
    logic [15:0] cnt2, cnt1;

    always #5 clk = ~clk;

    assign data2 = cpu_en[0] ? cpu_val : 16'hzzzz;
    assign data1 = cpu_en[1] ? cpu_val : 16'hzzzz;

    mem_bus_responder #(.LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM),
        .address(address), .data(data2), .inputReady(ready2), .busy(busy2),
        .proto_err(perr2), .acc_count(cnt2));

    mem_bus_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM),
        .address(address), .data(data1), .inputReady(ready1), .busy(busy1),
        .proto_err(perr1), .acc_count(cnt1));

    // Transaction-level reference: index 0 models LATENCY=2, index 1 LATENCY=1.
    int          edge_n;
    logic [15:0] m_mem [2][256];
    bit          m_pend [2], m_prd [2], m_perr [2], m_rdy [2], m_rdyrd [2];
    logic [7:0]  m_pa [2];
    logic [15:0] m_pd [2], m_cnt [2], m_rval [2];
    int          m_done [2], m_free [2];

    logic        s_rdy [2], s_busy [2], s_perr [2];
    logic [15:0] s_cnt [2], s_data [2];
    logic [15:0] last1;

    int vectors = 0;
    int miscompares = 0;

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s edge %0d: got %h expected %h", nm, edge_n, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_rdy[i]   = 1'b0;
            m_rdyrd[i] = 1'b0;
            if (!reset_n) begin
                m_pend[i] = 1'b0;
                m_perr[i] = 1'b0;
                m_cnt[i]  = 16'd0;
                m_free[i] = edge_n + 1;
            end else begin
                if (edge_n >= m_free[i]) begin
                    if (readM && writeM) begin
                        m_perr[i] = 1'b1;
                    end else if (readM || writeM) begin
                        m_pend[i] = 1'b1;
                        m_prd[i]  = readM;
                        m_pa[i]   = address[7:0];
                        m_pd[i]   = cpu_val;
                        m_done[i] = edge_n + lat(i) - 1;
                        m_free[i] = edge_n + lat(i) + 1;
                    end
                end
                if (m_pend[i] && edge_n == m_done[i]) begin
                    if (m_prd[i]) m_rval[i] = m_mem[i][m_pa[i]];
                    else          m_mem[i][m_pa[i]] = m_pd[i];
                    m_cnt[i]   = m_cnt[i] + 16'd1;
                    m_rdy[i]   = 1'b1;
                    m_rdyrd[i] = m_prd[i];
                    m_pend[i]  = 1'b0;
                end
            end
        end
        edge_n++;
    endtask

    task automatic cycle(input bit rn, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [15:0] d);
        reset_n = rn; readM = rd; writeM = wr; address = a; cpu_val = d;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 2; i++) cpu_en[i] = !(m_rdy[i] && m_rdyrd[i]);
        @(negedge clk);
        s_rdy[0] = ready2; s_busy[0] = busy2; s_perr[0] = perr2; s_cnt[0] = cnt2; s_data[0] = data2;
        s_rdy[1] = ready1; s_busy[1] = busy1; s_perr[1] = perr1; s_cnt[1] = cnt1; s_data[1] = data1;
        if (s_rdy[1] === 1'b1) last1 = s_data[1];
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready[%0d]", i), 16'(s_rdy[i]), 16'(m_rdy[i]));
            chk($sformatf("busy[%0d]", i), 16'(s_busy[i]), 16'(m_pend[i] || m_rdy[i]));
            chk($sformatf("proto_err[%0d]", i), 16'(s_perr[i]), 16'(m_perr[i]));
            chk($sformatf("acc_count[%0d]", i), s_cnt[i], m_cnt[i]);
            chk($sformatf("data[%0d]", i), s_data[i], (m_rdy[i] && m_rdyrd[i]) ? m_rval[i] : cpu_val);
        end
    endtask

    // Hold a request until the LATENCY=2 instance completes, then one idle cycle.
    task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, rd, wr, a, d);
            if (m_rdy[0]) break;
        end
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    typedef struct {
        bit          rn, rd, wr;
        logic [15:0] a, d;
        bit          e_rdy, e_busy, e_perr;
        logic [15:0] e_cnt, e_data;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(bit rn, bit rd, bit wr, logic [15:0] a, logic [15:0] d,
                                bit er, bit eb, bit ep, logic [15:0] ec, logic [15:0] ed);
        vec_t v;
        v.rn = rn; v.rd = rd; v.wr = wr; v.a = a; v.d = d;
        v.e_rdy = er; v.e_busy = eb; v.e_perr = ep; v.e_cnt = ec; v.e_data = ed;
        return v;
    endfunction

    initial begin
        reset_n = 1'b0; readM = 1'b0; writeM = 1'b0; address = '0; cpu_val = '0;
        cpu_en[0] = 1'b1; cpu_en[1] = 1'b1; edge_n = 0; last1 = '0;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_perr[i] = 0; m_cnt[i] = '0; m_free[i] = 0; m_done[i] = 0;
            m_rdy[i] = 0; m_rdyrd[i] = 0; m_rval[i] = '0;
        end
        @(negedge clk);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int a = 0; a < 256; a++) access(1'b0, 1'b1, 16'(a), 16'h0000);
        access(1'b0, 1'b1, 16'h0010, 16'hBEEF);

        // LATENCY=2 instance: rd=0x10, bubble, write/readback, proto_err, reset abort
        tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'd0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'd0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 1, 1, 0, 16'd1, 16'hBEEF));
        tbl.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'd1, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'd1, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 1, 1, 0, 16'd2, 16'hBEEF));
        tbl.push_back(mk(1, 0, 1, 16'h0005, 16'h1234, 0, 0, 0, 16'd2, 16'h1234));
        tbl.push_back(mk(1, 0, 1, 16'h0005, 16'h1234, 0, 1, 0, 16'd2, 16'h1234));
        tbl.push_back(mk(1, 0, 1, 16'h0005, 16'h1234, 1, 1, 0, 16'd3, 16'h1234));
        tbl.push_back(mk(1, 1, 0, 16'h0005, 16'h0000, 0, 0, 0, 16'd3, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 16'h0005, 16'h0000, 0, 1, 0, 16'd3, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 16'h0005, 16'h0000, 1, 1, 0, 16'd4, 16'h1234));
        tbl.push_back(mk(1, 1, 1, 16'h0005, 16'h0000, 0, 0, 0, 16'd4, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 16'h0005, 16'h0000, 0, 0, 1, 16'd4, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'd4, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 0, 1, 1, 16'd4, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'd5, 16'hBEEF));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'd5, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'd0, 16'h0000));
        tbl.push_back(mk(1, 0, 1, 16'h0007, 16'h5555, 0, 1, 0, 16'd0, 16'h5555));
        tbl.push_back(mk(0, 0, 1, 16'h0007, 16'h5555, 0, 0, 0, 16'd0, 16'h5555));
        tbl.push_back(mk(1, 1, 0, 16'h0007, 16'h0000, 0, 1, 0, 16'd0, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'd1, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'd1, 16'h0000));

        foreach (tbl[n]) begin
            cycle(tbl[n].rn, tbl[n].rd, tbl[n].wr, tbl[n].a, tbl[n].d);
            chk($sformatf("tbl%0d.ready", n), 16'(s_rdy[0]), 16'(tbl[n].e_rdy));
            chk($sformatf("tbl%0d.busy", n), 16'(s_busy[0]), 16'(tbl[n].e_busy));
            chk($sformatf("tbl%0d.proto_err", n), 16'(s_perr[0]), 16'(tbl[n].e_perr));
            chk($sformatf("tbl%0d.acc_count", n), s_cnt[0], tbl[n].e_cnt);
            chk($sformatf("tbl%0d.data", n), s_data[0], tbl[n].e_data);
        end

        // LATENCY=1 instance: response in the cycle right after accept, address wrap
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        cycle(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
        chk("lat1_ready_after_accept", 16'(s_rdy[1]), 16'd1);
        chk("lat1_read_data", s_data[1], 16'hBEEF);
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        access(1'b0, 1'b1, 16'h01FF, 16'hAAAA);
        last1 = 16'h0000;
        access(1'b1, 1'b0, 16'h00FF, 16'h0000);
        chk("lat1_wrap_readback", last1, 16'hAAAA);

        // Randomized traffic, occasional reset
        for (int n = 0; n < 1500; n++) begin
            int r;
            bit rn;
            r  = $urandom_range(0, 9);
            rn = ($urandom_range(0, 63) != 0);
            cycle(rn, (r <= 3) || (r == 8), (r >= 4 && r <= 8), 16'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
